apb_irq_aggregator: RTL and testbench

- APB3 slave that consumes interrupt lines such as TIMINT from the CoreTimer instance and other peripheral IRQs, and merges them into one registered interrupt for the MIV_RV32 core.
- Provides per-source synchronisation, a level/edge mode select, enable masking, W1C clearing, and a lowest-index claim register.
- Sits on the same APB segment and PCLK domain as the timer.

---
 rtl/apb_irq_aggregator_pkg.sv | 26 ++
 rtl/irq_sync_edge.sv | 45 ++++
 rtl/apb_irq_aggregator.sv | 103 ++++++++++
 tb/tb_apb_irq_aggregator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_irq_aggregator_pkg.sv
// Shared constants and helpers for the APB interrupt aggregator: register
// offsets, CLAIM layout and the lowest-index priority encoder.
`timescale 1ns/1ps
package apb_irq_aggregator_pkg;

    localparam int MAX_IRQ       = 32;
    localparam int CLAIM_VLD_BIT = 31;

    localparam logic [2:0] REG_RAW     = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_CLEAR   = 3'd3;
    localparam logic [2:0] REG_MODE    = 3'd4;
    localparam logic [2:0] REG_CLAIM   = 3'd5;

    // Scans from the top so the last hit is the lowest set index; 0 when empty.
    function automatic logic [4:0] lowest_index(input logic [MAX_IRQ-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser and rising-edge detector. SYNC_STAGES=0 passes the
// input straight through for sources already in the PCLK domain.
`timescale 1ns/1ps
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic irq_raw,
    output logic irq_s,
    output logic rise
);

    logic prev;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign irq_s = irq_raw;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= irq_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign irq_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // History is tracked in every mode so a level->edge switch sees no false rise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) prev <= 1'b0;
        else          prev <= irq_s;
    end

    assign rise = irq_s & ~prev;

endmodule

// File: rtl/apb_irq_aggregator.sv
// APB3 interrupt aggregator: synchronises NUM_IRQ sources, latches them per
// level/edge mode, masks with ENABLE and drives one registered interrupt.
`timescale 1ns/1ps
module apb_irq_aggregator
    import apb_irq_aggregator_pkg::*;
#(
    parameter int NUM_IRQ         = 8,
    parameter int SYNC_STAGES     = 2,
    parameter bit IRQ_ACTIVE_HIGH = 1'b1
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [2:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [NUM_IRQ-1:0]  irq_src,
    output logic                irq_o
);

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] masked;
    logic               wr_en;
    logic               unused_pwdata;

    function automatic logic [MAX_IRQ-1:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [MAX_IRQ-1:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    assign PREADY        = 1'b1;
    assign PSLVERR       = 1'b0;
    assign wr_en         = PSEL & PENABLE & PWRITE;
    assign unused_pwdata = ^PWDATA;

    genvar g;
    generate
        for (g = 0; g < NUM_IRQ; g++) begin : g_src
            irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .PCLK    (PCLK),
                .PRESETn (PRESETn),
                .irq_raw (irq_src[g]),
                .irq_s   (irq_s[g]),
                .rise    (rise[g])
            );
        end
    endgenerate

    // Pending update: set beats clear in edge mode; level mode simply follows the input.
    assign clr    = (wr_en && PADDR == REG_CLEAR) ? PWDATA[NUM_IRQ-1:0] : '0;
    assign pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & irq_s);
    assign masked = pend_q & enable_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            irq_o    <= !IRQ_ACTIVE_HIGH;
        end else begin
            pend_q <= pend_d;
            irq_o  <= IRQ_ACTIVE_HIGH ? (|masked) : !(|masked);
            if (wr_en) begin
                case (PADDR)
                    REG_ENABLE: enable_q <= PWDATA[NUM_IRQ-1:0];
                    REG_MODE:   mode_q   <= PWDATA[NUM_IRQ-1:0];
                    default:    ;
                endcase
            end
        end
    end

    // Read path is combinational from PADDR; CLEAR and reserved offsets read 0.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                REG_RAW:     PRDATA = zext(irq_s);
                REG_ENABLE:  PRDATA = zext(enable_q);
                REG_PENDING: PRDATA = zext(masked);
                REG_MODE:    PRDATA = zext(mode_q);
                REG_CLAIM: begin
                    PRDATA[CLAIM_VLD_BIT] = |masked;
                    PRDATA[4:0]           = lowest_index(zext(masked));
                end
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_aggregator.sv
// Self-checking bench for apb_irq_aggregator (NUM_IRQ=8, SYNC_STAGES=2, active-high).
`timescale 1ns/1ps
module tb_apb_irq_aggregator;
    import apb_irq_aggregator_pkg::*;

    localparam int NUM_IRQ = 8;

    logic               PCLK    = 1'b0;
    logic               PRESETn = 1'b0;
    logic               PSEL    = 1'b0;
    logic               PENABLE = 1'b0;
    logic               PWRITE  = 1'b0;
    logic [2:0]         PADDR   = '0;
    logic [31:0]        PWDATA  = '0;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;
    logic [NUM_IRQ-1:0] irq_src = '0;
    logic               irq_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct { string name; logic [31:0] exp; } rd_exp_t;
    typedef struct { int due; logic exp; string name; } irq_exp_t;
    typedef struct { logic wr; logic [2:0] addr; logic [31:0] data; string name; } vec_t;

    rd_exp_t  rd_q[$];
    irq_exp_t irq_q[$];
    vec_t     tbl[16];

    apb_irq_aggregator #(
        .NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2), .IRQ_ACTIVE_HIGH(1'b1)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_src(irq_src), .irq_o(irq_o)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // irq_o scoreboard: entries are due at a cycle count and checked mid-cycle.
    always @(negedge PCLK) begin
        irq_exp_t e;
        while (irq_q.size() > 0 && irq_q[0].due <= cyc) begin
            e = irq_q.pop_front();
            check(e.name, 32'(irq_o), 32'(e.exp));
        end
    end

    task automatic expect_irq(input int dly, input logic v, input string name);
        irq_exp_t e;
        e.due = cyc + dly;
        e.exp = v;
        e.name = name;
        irq_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Returns 1ns after the commit edge.
    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        e = rd_q.pop_front();
        check(e.name, PRDATA, e.exp);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, REG_ENABLE,  32'hFFFF_FFFF, "w_enable"};
        tbl[1]  = '{1'b0, REG_ENABLE,  32'h0000_00FF, "enable_upper_bits"};
        tbl[2]  = '{1'b1, REG_MODE,    32'hA5A5_A5A5, "w_mode"};
        tbl[3]  = '{1'b0, REG_MODE,    32'h0000_00A5, "mode_rw"};
        tbl[4]  = '{1'b1, 3'd6,        32'hFFFF_FFFF, "w_rsvd6"};
        tbl[5]  = '{1'b0, 3'd6,        32'h0000_0000, "rsvd6_reads0"};
        tbl[6]  = '{1'b0, 3'd7,        32'h0000_0000, "rsvd7_reads0"};
        tbl[7]  = '{1'b1, REG_CLEAR,   32'h0000_00FF, "w_clear"};
        tbl[8]  = '{1'b0, REG_CLEAR,   32'h0000_0000, "clear_reads0"};
        tbl[9]  = '{1'b1, REG_RAW,     32'h0000_00FF, "w_raw"};
        tbl[10] = '{1'b0, REG_RAW,     32'h0000_0000, "raw_ro"};
        tbl[11] = '{1'b0, REG_CLAIM,   32'h0000_0000, "claim_idle"};
        tbl[12] = '{1'b1, REG_ENABLE,  32'h0000_0000, "w_enable0"};
        tbl[13] = '{1'b1, REG_MODE,    32'h0000_0000, "w_mode0"};
        tbl[14] = '{1'b0, REG_ENABLE,  32'h0000_0000, "enable_cleared"};
        tbl[15] = '{1'b0, REG_MODE,    32'h0000_0000, "mode_cleared"};

        // Reset held with all sources high
        irq_src = 8'hFF;
        PRESETn = 1'b0;
        tick(3);
        check("rst_irq_o", 32'(irq_o), 32'h0);
        check("pready", 32'(PREADY), 32'h1);
        check("pslverr", 32'(PSLVERR), 32'h0);
        for (int a = 0; a < 8; a++) apb_read(3'(a), 32'h0, "rst_read");
        PRESETn = 1'b1;
        tick(3);
        apb_read(REG_RAW, 32'h0000_00FF, "raw_after_rst");
        irq_src = '0;
        tick(5);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else           apb_read(tbl[i].addr, tbl[i].data, tbl[i].name);
        end

        // Level mode on the timer source: 4-cycle latency both ways, CLEAR ignored
        apb_write(REG_ENABLE, 32'h01);
        tick(1);
        irq_src[0] = 1'b1;
        expect_irq(3, 1'b0, "lvl_not_early");
        expect_irq(4, 1'b1, "lvl_assert_lat");
        tick(6);
        apb_write(REG_CLEAR, 32'h01);
        apb_read(REG_PENDING, 32'h01, "lvl_clear_noeffect");
        check("lvl_irq_held", 32'(irq_o), 32'h1);
        irq_src[0] = 1'b0;
        expect_irq(3, 1'b1, "lvl_not_early_drop");
        expect_irq(4, 1'b0, "lvl_deassert_lat");
        tick(6);
        apb_read(REG_PENDING, 32'h0, "lvl_pend_drop");

        // Edge mode: one-cycle pulse latches; W1C drops irq_o one cycle later
        apb_write(REG_MODE, 32'h0C);
        apb_write(REG_ENABLE, 32'h0C);
        tick(1);
        irq_src[3] = 1'b1;
        expect_irq(3, 1'b0, "edge_not_early");
        expect_irq(4, 1'b1, "edge_assert_lat");
        tick(1);
        irq_src[3] = 1'b0;
        tick(4);
        apb_read(REG_PENDING, 32'h08, "edge_pending");
        apb_read(REG_CLAIM, 32'h8000_0003, "edge_claim");
        apb_read(REG_CLAIM, 32'h8000_0003, "claim_no_side_effect");
        apb_write(REG_CLEAR, 32'h08);
        expect_irq(0, 1'b1, "w1c_commit_cycle");
        expect_irq(1, 1'b0, "w1c_irq_drop");
        apb_read(REG_PENDING, 32'h0, "w1c_pending");

        // Rise landing on the CLEAR commit edge keeps the bit set
        tick(1);
        irq_src[2] = 1'b1;
        tick(1);
        irq_src[2] = 1'b0;
        tick(5);
        apb_read(REG_PENDING, 32'h04, "bit2_latched");
        tick(1);
        irq_src[2] = 1'b1;
        apb_write(REG_CLEAR, 32'h04);
        apb_read(REG_PENDING, 32'h04, "rise_beats_clear");
        apb_write(REG_CLEAR, 32'h04);
        apb_read(REG_PENDING, 32'h0, "clear_without_rise");
        irq_src[2] = 1'b0;
        tick(4);

        // Masking and claim priority
        apb_write(REG_MODE, 32'h0A);
        apb_write(REG_ENABLE, 32'h08);
        tick(1);
        irq_src = 8'h0A;
        expect_irq(4, 1'b1, "mask_irq_assert");
        tick(1);
        irq_src = 8'h00;
        tick(5);
        apb_read(REG_PENDING, 32'h08, "mask_pending");
        apb_read(REG_CLAIM, 32'h8000_0003, "mask_claim");
        apb_write(REG_ENABLE, 32'h0A);
        apb_read(REG_CLAIM, 32'h8000_0001, "claim_lowest");
        apb_write(REG_ENABLE, 32'h00);
        expect_irq(0, 1'b1, "disable_commit_cycle");
        expect_irq(1, 1'b0, "disable_irq_drop");
        apb_read(REG_CLAIM, 32'h0, "claim_disabled");
        apb_read(REG_PENDING, 32'h0, "pending_disabled");
        apb_read(REG_RAW, 32'h0, "raw_unchanged");
        apb_write(REG_ENABLE, 32'h0A);
        expect_irq(0, 1'b0, "reenable_commit_cycle");
        expect_irq(1, 1'b1, "reenable_irq");
        apb_read(REG_PENDING, 32'h0A, "pend_kept_while_disabled");

        // Asynchronous reset between clock edges
        tick(2);
        check("pre_async_irq", 32'(irq_o), 32'h1);
        @(posedge PCLK);
        #3;
        PRESETn = 1'b0;
        #1;
        check("async_rst_irq", 32'(irq_o), 32'h0);
        #2;
        PRESETn = 1'b1;
        apb_read(REG_ENABLE, 32'h0, "async_rst_enable");
        apb_read(REG_MODE, 32'h0, "async_rst_mode");
        apb_read(REG_PENDING, 32'h0, "async_rst_pending");
        tick(2);
        check("post_rst_irq", 32'(irq_o), 32'h0);
        check("irq_sb_drained", 32'(irq_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
